sram_port_arbiter: RTL

//  Shares the single 16-bit activation SRAM port between two masters: requester 0 (the conv controller)
//  and requester 1 (the host/loader that fills inputs and drains outputs between layers).

---
 rtl/sram_port_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one activation SRAM port between the conv controller (r0) and host/loader (r1).
// Optional `ARB_STATS_EN adds per-master access counters and a stall counter.
module sram_port_arbiter #(
    parameter int AW        = 12,
    parameter int DW        = 16,
    parameter int MAX_BURST = 16,
    parameter int RD_LAT    = 1
) (
    input  logic          clk,
    input  logic          reset_b,
    input  logic          r0_req,
    input  logic          r0_lock,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_lock,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    input  logic [DW-1:0] sram_read_data,
    output logic [AW-1:0] sram_read_address,
    output logic [AW-1:0] sram_write_address,
    output logic [DW-1:0] sram_write_data,
    output logic          sram_write_enable,
`ifdef ARB_STATS_EN
    output logic [15:0]   stat_gnt0_cnt,
    output logic [15:0]   stat_gnt1_cnt,
    output logic [15:0]   stat_stall_cnt,
`endif
    output logic [1:0]    dbg_owner
);

    // Handshake: rN_req acts as valid and rN_gnt as ready. An access happens only in a cycle
    // where both are high; the master holds req/addr/we/wdata stable until it sees that cycle.

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_t;

    owner_t        owner_q;
    owner_t        owner_d;
    logic          last_owner_q;
    logic [CW-1:0] burst_cnt_q;
    logic          below_cap;
    logic          acc0;
    logic          acc1;
    logic          rd_in;
    logic [RD_LAT-1:0] rd_vld_q;
    logic [RD_LAT-1:0] rd_id_q;

    assign r0_gnt    = (owner_q == OWN0);
    assign r1_gnt    = (owner_q == OWN1);
    assign acc0      = r0_gnt & r0_req;
    assign acc1      = r1_gnt & r1_req;
    assign below_cap = (burst_cnt_q < BURST_LAST);
    assign dbg_owner = owner_q;

    always_comb begin
        owner_d = IDLE;
        if (r0_gnt && r0_req && r0_lock && (below_cap || !r1_req)) begin
            owner_d = OWN0;
        end else if (r1_gnt && r1_req && r1_lock && (below_cap || !r0_req)) begin
            owner_d = OWN1;
        end else if (r0_req && r1_req) begin
            // Tie goes to whoever did not own the port most recently.
            owner_d = last_owner_q ? OWN0 : OWN1;
        end else if (r0_req) begin
            owner_d = OWN0;
        end else if (r1_req) begin
            owner_d = OWN1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            owner_q      <= IDLE;
            last_owner_q <= 1'b1;
            burst_cnt_q  <= '0;
        end else begin
            owner_q <= owner_d;
            if (owner_d == OWN0) begin
                last_owner_q <= 1'b0;
            end else if (owner_d == OWN1) begin
                last_owner_q <= 1'b1;
            end
            // Wrapping at the cap lets a locked owner continue while the other side is quiet.
            if ((owner_d != owner_q) || (owner_q == IDLE) || (burst_cnt_q == BURST_LAST)) begin
                burst_cnt_q <= '0;
            end else begin
                burst_cnt_q <= burst_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        sram_read_address  = '0;
        sram_write_address = '0;
        sram_write_data    = '0;
        sram_write_enable  = 1'b0;
        if (acc0) begin
            sram_read_address  = r0_addr;
            sram_write_address = r0_addr;
            sram_write_data    = r0_wdata;
            sram_write_enable  = r0_we;
        end else if (acc1) begin
            sram_read_address  = r1_addr;
            sram_write_address = r1_addr;
            sram_write_data    = r1_wdata;
            sram_write_enable  = r1_we;
        end
    end

    assign rd_in = (acc0 & ~r0_we) | (acc1 & ~r1_we);

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            rd_vld_q <= '0;
            rd_id_q  <= '0;
        end else begin
            rd_vld_q[0] <= rd_in;
            rd_id_q[0]  <= acc1;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
                rd_id_q[i]  <= rd_id_q[i-1];
            end
        end
    end

    assign r0_rvalid = rd_vld_q[RD_LAT-1] & ~rd_id_q[RD_LAT-1];
    assign r1_rvalid = rd_vld_q[RD_LAT-1] &  rd_id_q[RD_LAT-1];
    assign r0_rdata  = sram_read_data;
    assign r1_rdata  = sram_read_data;

`ifdef ARB_STATS_EN
    logic stall;
    assign stall = (r0_req & ~r0_gnt) | (r1_req & ~r1_gnt);

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            stat_gnt0_cnt  <= '0;
            stat_gnt1_cnt  <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (acc0 && (stat_gnt0_cnt != 16'hFFFF)) begin
                stat_gnt0_cnt <= stat_gnt0_cnt + 16'd1;
            end
            if (acc1 && (stat_gnt1_cnt != 16'hFFFF)) begin
                stat_gnt1_cnt <= stat_gnt1_cnt + 16'd1;
            end
            if (stall && (stat_stall_cnt != 16'hFFFF)) begin
                stat_stall_cnt <= stat_stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
